// File: rtl/button_pattern_player.sv
// Replays a stored HIGH/LOW symbol sequence on two raw button lines with a start/busy/done handshake.
// Optional contact-bounce emulation at the start of each press: define PATTERN_PLAYER_BOUNCE_EN.
module button_pattern_player #(
  parameter int PATTERN_LEN   = 8,
  parameter int PRESS_CYCLES  = 65536,
  parameter int GAP_CYCLES    = 65536,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic                               sysclock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [PATTERN_LEN-1:0]             pattern,
  input  logic [$clog2(PATTERN_LEN+1)-1:0]   length,
  output logic [1:0]                         press,
  output logic                               busy,
  output logic                               done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // PRESS | driving the line selected by the current symbol
  // GAP   | both lines released between presses
  // DONE  | one-cycle done pulse, busy still high

  localparam int LW    = $clog2(PATTERN_LEN+1);
  localparam int MAXC  = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] P_LOAD = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [LW-1:0]          idx, len_q, len_clamped;
  logic [PATTERN_LEN-1:0] pat_q, pat_shift;
  logic                   last_sym, sym, act;

  assign len_clamped = (length > LW'(PATTERN_LEN)) ? LW'(PATTERN_LEN) : length;
  assign last_sym    = ((idx + LW'(1)) == len_q);
  assign pat_shift   = pat_q >> idx;
  assign sym         = pat_shift[0];

  always_ff @(posedge sysclock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      len_q <= '0;
      pat_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        pat_q <= pattern;
        len_q <= len_clamped;
        idx   <= '0;
      end
      if (state == GAP && cnt == '0 && !last_sym)
        idx <= idx + LW'(1);
      // duration counter reloads on every state entry so phases never share a count
      if (state_nxt != state) begin
        case (state_nxt)
          PRESS:   cnt <= P_LOAD;
          GAP:     cnt <= G_LOAD;
          default: cnt <= '0;
        endcase
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (len_clamped == '0) ? DONE : PRESS;
      PRESS: if (cnt == '0) state_nxt = GAP;
      GAP:   if (cnt == '0) state_nxt = last_sym ? DONE : PRESS;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PATTERN_PLAYER_BOUNCE_EN
  logic [CW-1:0] elapsed;
  assign elapsed = P_LOAD - cnt;
  // bounce toggles 1,0,1,... from the first press cycle, then settles high
  assign act = (elapsed < CW'(BOUNCE_CYCLES)) ? ~elapsed[0] : 1'b1;
`else
  localparam int bounce_unused = BOUNCE_CYCLES;
  assign act = 1'b1;
`endif

  always_comb begin
    press = 2'b00;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      PRESS: begin
        busy  = 1'b1;
        press = sym ? {act, 1'b0} : {1'b0, act};
      end
      GAP:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/button_pattern_player.md
# button_pattern_player

Stimulus-side counterpart to the two-button pattern detector: replays a stored sequence of button presses on two raw button lines, `press[1]` (HIGH symbol) and `press[0]` (LOW symbol), with press and release durations long enough to pass the debouncers. A start/busy/done handshake controls it. It sits on the board or bench side, driving the detector's `raw_button[1:0]` inputs so detection can be exercised without hand presses.

## Interface
- PATTERN_LEN, 8: maximum number of symbols per run.
- PRESS_CYCLES, 65536: cycles each press is held active. Must be ≥ 1 and exceed the debounce count.
- GAP_CYCLES, 65536: cycles both lines are held low after each press. Must be ≥ 1.
- BOUNCE_CYCLES, 8: bounce length. Used only with PATTERN_PLAYER_BOUNCE_EN. Must be < PRESS_CYCLES.
- sysclock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- pattern  in  PATTERN_LEN  symbols; bit i is symbol i, 1 = press[1], 0 = press[0]; captured on accepted start.
- length  in  $clog2(PATTERN_LEN+1)  number of symbols to play; captured on accepted start.
- press  out  2  raw button drive; at most one bit high at any time.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse ending a run.

## Operation
- Reset values: press=2'b00, busy=0, done=0, state IDLE, counters 0.
- States: IDLE, PRESS, GAP, DONE.
- IDLE
  - start=1 captures pattern and length; a captured length > PATTERN_LEN is clamped to PATTERN_LEN.
  - Symbol index is set to 0.
  - Next state is PRESS, or DONE if the captured length is 0.
- PRESS
  - press[pattern[idx]]=1; the other bit is 0.
  - Held PRESS_CYCLES cycles, then GAP.
- GAP
  - press=00, held GAP_CYCLES cycles.
  - Then idx increments. If idx+1 == length, go to DONE; otherwise go to PRESS.
- DONE
  - done=1 and busy=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE, including during DONE. pattern and length changes after capture have no effect.
- Duration counter width is $clog2(max(PRESS_CYCLES,GAP_CYCLES)). It reloads on every state entry, with no wrap between phases.
- reset=1 in any state forces reset values at the next edge. A press in progress is cut off and no done is issued.

## Timing
- Start accepted at edge k. From cycle k+1: busy=1, and press is driven for symbol 0, or done=1 if length is 0.
- Symbol j press occupies cycles k+1+j·(PRESS_CYCLES+GAP_CYCLES) through that value + PRESS_CYCLES−1.
- done is high in cycle k+1+L·(PRESS_CYCLES+GAP_CYCLES), for L symbols.
- busy falls the cycle after done. start may be accepted in that cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- PATTERN_PLAYER_BOUNCE_EN defined: the first BOUNCE_CYCLES cycles of each PRESS toggle the active line every cycle, starting at 1. The line is then held at 1 for the remaining PRESS_CYCLES−BOUNCE_CYCLES cycles. The inactive line stays 0, and total PRESS duration is unchanged.
- Not defined: the active line is a clean level for all PRESS_CYCLES. BOUNCE_CYCLES is unused.

## Test plan
(PATTERN_LEN=8, PRESS_CYCLES=4, GAP_CYCLES=2, BOUNCE_CYCLES=2)
- Reset held 3 cycles, then released with start=0 → press=00, busy=0, done=0 indefinitely.
- start pulse, pattern=8'b0000_0101, length=3 → from the cycle after start:
  - press=10 ×4, then 00 ×2;
  - press=01 ×4, then 00 ×2;
  - press=10 ×4, then 00 ×2;
  - done=1 on cycle 19, busy=1 on cycles 1–19.
- length=0 → done=1 on cycle 1, press never leaves 00, busy=1 for one cycle only.
- length=12 with pattern=8'hFF → clamped to 8; press=10 pulses ×8; done on cycle 49.
- Second start during PRESS, and start during DONE → both ignored. A start in the cycle after done begins a new run one cycle later.
- reset asserted mid-PRESS of symbol 1 → press=00 and busy=0 the next cycle, no done. With BOUNCE_EN, each press reads 1,0,1,1 on the active line.
